// File: rtl/dpram_pkg.sv
// dpram_pkg: shared types and helpers for the dpram dual-port RAM.
//   dpram_state_e : INIT (zero-fill) / RUN (serving requests)
//   byte_parity   : even-parity bit per byte of a word
//   be_merge      : byte-enable merge of new data over old data
// Helpers work on MAX_DW-wide vectors; callers zero-extend and truncate,
// so any DW up to MAX_DW (multiple of 8) is supported.
package dpram_pkg;

  localparam int unsigned MAX_DW = 256;
  localparam int unsigned MAX_NB = MAX_DW / 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } dpram_state_e;

  // One even-parity bit per byte: bit set when the byte has an odd number of ones.
  function automatic logic [MAX_NB-1:0] byte_parity(input logic [MAX_DW-1:0] d);
    logic [MAX_NB-1:0] p;
    p = '0;
    for (int i = 0; i < int'(MAX_NB); i++) begin
      p[i] = ^d[i*8 +: 8];
    end
    return p;
  endfunction

  // Enabled bytes come from nw_d, the rest from old_d.
  function automatic logic [MAX_DW-1:0] be_merge(input logic [MAX_DW-1:0] old_d,
                                                 input logic [MAX_DW-1:0] nw_d,
                                                 input logic [MAX_NB-1:0] be);
    logic [MAX_DW-1:0] r;
    r = old_d;
    for (int i = 0; i < int'(MAX_NB); i++) begin
      if (be[i]) r[i*8 +: 8] = nw_d[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dpram_arb.sv
// dpram_arb: same-address collision and cross-port forwarding decisions.
//   a_valid/a_we/a_addr, b_valid/b_we/b_addr : raw port requests
//   b_stall    : both write the same address; A wins, B retries next cycle
//   a_fwd_to_b : A writes the address B reads this cycle
//   b_fwd_to_a : B writes the address A reads this cycle
// Pure combinational; the top gates everything with its RUN state.
module dpram_arb
  import dpram_pkg::*;
#(
  parameter int unsigned AW = 12
) (
  input  logic          a_valid,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic          b_valid,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  output logic          b_stall,
  output logic          a_fwd_to_b,
  output logic          b_fwd_to_a
);

  logic same;

  assign same       = a_valid & b_valid & (a_addr == b_addr);
  assign b_stall    = same & a_we & b_we;
  assign a_fwd_to_b = same & a_we & ~b_we;
  assign b_fwd_to_a = same & b_we & ~a_we;

endmodule

// File: rtl/dpram.sv
// dpram: single-clock dual-port RAM, 2**AW words of DW bits, byte enables.
//   clk, rst_n                 : clock, async active-low reset
//   init_done                  : zero-fill complete, ports serving
//   x_valid/x_ready            : request handshake (x = a, b)
//   x_we, x_addr, x_be, x_wdata : request payload
//   x_rvalid, x_rdata, x_perr  : read response, one cycle after acceptance
// Optional macro DPRAM_PARITY_EN adds a stored even-parity bit per byte and
// drives x_perr; without it x_perr is tied low.
module dpram
  import dpram_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            init_done,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic            a_we,
  input  logic [AW-1:0]   a_addr,
  input  logic [DW/8-1:0] a_be,
  input  logic [DW-1:0]   a_wdata,
  output logic            a_rvalid,
  output logic [DW-1:0]   a_rdata,
  output logic            a_perr,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic            b_we,
  input  logic [AW-1:0]   b_addr,
  input  logic [DW/8-1:0] b_be,
  input  logic [DW-1:0]   b_wdata,
  output logic            b_rvalid,
  output logic [DW-1:0]   b_rdata,
  output logic            b_perr
);

  localparam int unsigned NB    = DW / 8;
  localparam int unsigned DEPTH = 2 ** AW;

  dpram_state_e  state;
  logic [AW-1:0] init_cnt;
  logic          run;
  logic          b_stall, a_fwd_to_b, b_fwd_to_a;
  logic          a_wr, a_rd, b_wr, b_rd;
  logic [DW-1:0] a_old, b_old, a_wword, b_wword, a_rword, b_rword;

  logic [DW-1:0] mem [DEPTH];

  dpram_arb #(.AW(AW)) u_arb (
    .a_valid    (a_valid),
    .a_we       (a_we),
    .a_addr     (a_addr),
    .b_valid    (b_valid),
    .b_we       (b_we),
    .b_addr     (b_addr),
    .b_stall    (b_stall),
    .a_fwd_to_b (a_fwd_to_b),
    .b_fwd_to_a (b_fwd_to_a)
  );

  // INIT walks every address once, then RUN forever until the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + AW'(1);
      if (init_cnt == '1) begin
        state     <= RUN;
        init_done <= 1'b1;
      end
    end
  end

  assign run     = (state == RUN);
  assign a_ready = run;
  assign b_ready = run & ~b_stall;

  assign a_wr = a_valid & a_ready & a_we;
  assign a_rd = a_valid & a_ready & ~a_we;
  assign b_wr = b_valid & b_ready & b_we;
  assign b_rd = b_valid & b_ready & ~b_we;

  assign a_old   = mem[a_addr];
  assign b_old   = mem[b_addr];
  assign a_wword = DW'(be_merge(MAX_DW'(a_old), MAX_DW'(a_wdata), MAX_NB'(a_be)));
  assign b_wword = DW'(be_merge(MAX_DW'(b_old), MAX_DW'(b_wdata), MAX_NB'(b_be)));

  // Write-first: a read colliding with the other port's write sees the merged word.
  assign a_rword = b_fwd_to_a ? b_wword : a_old;
  assign b_rword = a_fwd_to_b ? a_wword : b_old;

  // Storage array; same-address double writes never reach here (B is stalled).
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[init_cnt] <= '0;
    end else begin
      if (a_wr) mem[a_addr] <= a_wword;
      if (b_wr) mem[b_addr] <= b_wword;
    end
  end

  // Read response registers; rdata holds between rvalid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= a_rd;
      b_rvalid <= b_rd;
      if (a_rd) a_rdata <= a_rword;
      if (b_rd) b_rdata <= b_rword;
    end
  end

`ifdef DPRAM_PARITY_EN
  logic [NB-1:0] par [DEPTH];
  logic [NB-1:0] a_wpar, b_wpar, a_spar, b_spar, a_rpar, b_rpar;
  logic          a_perr_c, b_perr_c;

  assign a_wpar = NB'(byte_parity(MAX_DW'(a_wdata)));
  assign b_wpar = NB'(byte_parity(MAX_DW'(b_wdata)));
  assign a_spar = (par[a_addr] & ~a_be) | (a_wpar & a_be);
  assign b_spar = (par[b_addr] & ~b_be) | (b_wpar & b_be);

  // Forwarded bytes carry the writer's parity, so forwarding never flags an error.
  assign a_rpar   = b_fwd_to_a ? b_spar : par[a_addr];
  assign b_rpar   = a_fwd_to_b ? a_spar : par[b_addr];
  assign a_perr_c = |(NB'(byte_parity(MAX_DW'(a_rword))) ^ a_rpar);
  assign b_perr_c = |(NB'(byte_parity(MAX_DW'(b_rword))) ^ b_rpar);

  // Parity array tracks the data array write-for-write; zero data has zero parity.
  always_ff @(posedge clk) begin
    if (!run) begin
      par[init_cnt] <= '0;
    end else begin
      if (a_wr) par[a_addr] <= a_spar;
      if (b_wr) par[b_addr] <= b_spar;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_perr <= 1'b0;
      b_perr <= 1'b0;
    end else begin
      if (a_rd) a_perr <= a_perr_c;
      if (b_rd) b_perr <= b_perr_c;
    end
  end
`else
  assign a_perr = 1'b0;
  assign b_perr = 1'b0;
`endif

endmodule

// File: tb/tb_dpram.sv
// tb_dpram: scoreboard bench for dpram (DW=32, AW=12).
// Read requests push their expected response; a negedge monitor pops and
// compares whenever a port presents rvalid. Define DPRAM_PARITY_EN for both
// files to exercise the parity path.
module tb_dpram;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done;
  logic        a_valid = 1'b0, a_ready, a_we = 1'b0, a_rvalid, a_perr;
  logic [11:0] a_addr = '0;
  logic [3:0]  a_be = '0;
  logic [31:0] a_wdata = '0, a_rdata;
  logic        b_valid = 1'b0, b_ready, b_we = 1'b0, b_rvalid, b_perr;
  logic [11:0] b_addr = '0;
  logic [3:0]  b_be = '0;
  logic [31:0] b_wdata = '0, b_rdata;

  typedef struct {
    logic [31:0] data;
    logic        perr;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  dpram #(.DW(32), .AW(12)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .init_done(init_done),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_be     (a_be),
    .a_wdata  (a_wdata),
    .a_rvalid (a_rvalid),
    .a_rdata  (a_rdata),
    .a_perr   (a_perr),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_be     (b_be),
    .b_wdata  (b_wdata),
    .b_rvalid (b_rvalid),
    .b_rdata  (b_rdata),
    .b_perr   (b_perr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor for both read ports.
  always @(negedge clk) begin
    exp_t e;
    if (a_rvalid) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_rvalid", 32'(a_rvalid), 32'd0);
      end else begin
        e = qa.pop_front();
        chk("a_rdata", a_rdata, e.data);
        chk("a_perr", 32'(a_perr), 32'(e.perr));
        chk("a_latency", 32'(cyc - e.cyc), 32'd1);
      end
    end
    if (b_rvalid) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_rvalid", 32'(b_rvalid), 32'd0);
      end else begin
        e = qb.pop_front();
        chk("b_rdata", b_rdata, e.data);
        chk("b_perr", 32'(b_perr), 32'(e.perr));
        chk("b_latency", 32'(cyc - e.cyc), 32'd1);
      end
    end
  end

  task automatic a_rd(input logic [11:0] ad, input logic [31:0] ex, input logic pe);
    a_valid = 1'b1; a_we = 1'b0; a_addr = ad; a_be = '0; a_wdata = '0;
    qa.push_back('{data: ex, perr: pe, cyc: cyc});
  endtask

  task automatic b_rd(input logic [11:0] ad, input logic [31:0] ex, input logic pe);
    b_valid = 1'b1; b_we = 1'b0; b_addr = ad; b_be = '0; b_wdata = '0;
    qb.push_back('{data: ex, perr: pe, cyc: cyc});
  endtask

  task automatic a_wr(input logic [11:0] ad, input logic [3:0] be, input logic [31:0] d);
    a_valid = 1'b1; a_we = 1'b1; a_addr = ad; a_be = be; a_wdata = d;
  endtask

  task automatic b_wr(input logic [11:0] ad, input logic [3:0] be, input logic [31:0] d);
    b_valid = 1'b1; b_we = 1'b1; b_addr = ad; b_be = be; b_wdata = d;
  endtask

  // Advance one cycle (ends on the next negedge) and drop both requests.
  task automatic tick();
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_init_done"}, 32'(init_done), 32'd0);
    chk({tag, "_ready"}, {30'd0, a_ready, b_ready}, 32'd0);
    chk({tag, "_rvalid"}, {30'd0, a_rvalid, b_rvalid}, 32'd0);
    chk({tag, "_a_rdata"}, a_rdata, 32'd0);
    chk({tag, "_b_rdata"}, b_rdata, 32'd0);
    chk({tag, "_perr"}, {30'd0, a_perr, b_perr}, 32'd0);
  endtask

  // Release reset on a negedge and count rising edges until init_done.
  task automatic release_and_wait_init();
    int n;
    n = 0;
    rst_n = 1'b1;
    for (int i = 1; i <= 5000; i++) begin
      @(posedge clk);
      #1;
      if (i == 100) chk("init_a_ready_low", 32'(a_ready), 32'd0);
      if (init_done) begin
        n = i;
        break;
      end
    end
    chk("init_done_cycle", 32'(n), 32'd4096);
    chk("run_ready", {30'd0, a_ready, b_ready}, 32'd3);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    release_and_wait_init();

    // Zero-filled corners
    a_rd(12'h000, 32'h0000_0000, 1'b0);
    b_rd(12'hFFF, 32'h0000_0000, 1'b0);
    tick();

    // Cross-port forwarding, full word
    a_wr(12'h010, 4'b1111, 32'hDEAD_BEEF);
    b_rd(12'h010, 32'hDEAD_BEEF, 1'b0);
    tick();

    // Write-write collision: B stalls one cycle then retries
    a_wr(12'h020, 4'b0011, 32'h1111_2222);
    b_wr(12'h020, 4'b1111, 32'hAAAA_BBBB);
    #1;
    chk("collide_b_ready", 32'(b_ready), 32'd0);
    chk("collide_a_ready", 32'(a_ready), 32'd1);
    tick();
    b_wr(12'h020, 4'b1111, 32'hAAAA_BBBB);
    #1;
    chk("retry_b_ready", 32'(b_ready), 32'd1);
    tick();
    a_rd(12'h020, 32'hAAAA_BBBB, 1'b0);
    tick();

    // Byte-enable partial write
    a_wr(12'h030, 4'b1111, 32'h1234_5678);
    tick();
    b_wr(12'h030, 4'b0100, 32'h00FF_0000);
    tick();
    a_rd(12'h030, 32'h12FF_5678, 1'b0);
    tick();

    // Partial forwarding B -> A: enabled byte new, the rest old
    b_wr(12'h030, 4'b0001, 32'h0000_00AA);
    a_rd(12'h030, 32'h12FF_56AA, 1'b0);
    tick();

    // Independent writes at different addresses
    a_wr(12'h050, 4'b1111, 32'hCAFE_F00D);
    b_wr(12'h051, 4'b1111, 32'h0BAD_C0DE);
    #1;
    chk("diff_addr_b_ready", 32'(b_ready), 32'd1);
    tick();

    // Back-to-back reads, including both ports on one address
    a_rd(12'h010, 32'hDEAD_BEEF, 1'b0);
    b_rd(12'h010, 32'hDEAD_BEEF, 1'b0);
    tick();
    a_rd(12'h050, 32'hCAFE_F00D, 1'b0);
    b_rd(12'h051, 32'h0BAD_C0DE, 1'b0);
    tick();
    a_rd(12'h030, 32'h12FF_56AA, 1'b0);
    b_rd(12'h020, 32'hAAAA_BBBB, 1'b0);
    tick();

`ifdef DPRAM_PARITY_EN
    // Stored bit flip is caught; clean read on the other port is not flagged
    a_wr(12'h040, 4'b1111, 32'h0102_0304);
    tick();
    dut.mem[12'h040] = dut.mem[12'h040] ^ 32'h0000_0001;
    a_rd(12'h040, 32'h0102_0305, 1'b1);
    b_rd(12'h010, 32'hDEAD_BEEF, 1'b0);
    tick();
    a_rd(12'h050, 32'hCAFE_F00D, 1'b0);
    tick();
`endif

    // Reset while reads are in flight: no rvalid, outputs cleared
    a_valid = 1'b1; a_we = 1'b0; a_addr = 12'h010;
    b_valid = 1'b1; b_we = 1'b0; b_addr = 12'h030;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    chk_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    chk_reset_outputs("midrst_hold");
    release_and_wait_init();

    // Memory zero-filled again
    a_rd(12'h010, 32'h0000_0000, 1'b0);
    b_rd(12'h030, 32'h0000_0000, 1'b0);
    tick();
    a_rd(12'h020, 32'h0000_0000, 1'b0);
    tick();
    repeat (3) tick();

    chk("a_queue_drained", 32'(qa.size()), 32'd0);
    chk("b_queue_drained", 32'(qb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dpram.md
# dpram

Parametrised single-clock dual-port RAM for SoC-local instruction/data storage. Successor to the fixed 32x4096 dual-port ROM: generalised data width and depth, byte-enable writes, and valid/ready request ports. Adds deterministic same-address collision arbitration, cross-port write-first forwarding and a post-reset zero-fill sequencer. Sits between the core fetch/load-store units and the bus fabric.

## Interface
- DW, 32, data width in bits; multiple of 8
- AW, 12, address width; depth = 2**AW words
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- init_done  out  1  high once zero-fill completes
- a_valid, b_valid  in  1  request present on port A / B
- a_ready, b_ready  out  1  request accepted this cycle when valid & ready
- a_we, b_we  in  1  1 = write, 0 = read
- a_addr, b_addr  in  AW  word address
- a_be, b_be  in  DW/8  byte enables, writes only
- a_wdata, b_wdata  in  DW  write data
- a_rvalid, b_rvalid  out  1  read data valid, one cycle after read acceptance
- a_rdata, b_rdata  out  DW  read data; held between rvalid pulses
- a_perr, b_perr  out  1  parity error, qualified by rvalid

## Operation
- FSM states: INIT, RUN.
- INIT:
  - Entered on reset.
  - Counter walks addresses 0..2**AW-1, writing zero at one address per cycle.
  - a_ready = b_ready = 0.
  - After the last address is written: go to RUN, assert init_done.
- RUN:
  - a_ready = 1 always.
  - b_ready = 0 only on a collision stall (defined below); otherwise 1.
- Collision (both valid, both writes, same addr): A's write is accepted, B stalls one cycle (b_ready = 0). B retries the next cycle, so B's data is final.
- Writes: only bytes with be[i] = 1 are updated.
- Read during write, same addr:
  - Same port: impossible (a port does one operation per cycle).
  - Cross port: the reader returns the new data. Enabled bytes come from the writer's wdata, the other bytes from the old memory contents (write-first forwarding).
- Different addresses: fully independent.
- Both ports reading the same address: both served.
- rdata and perr update only when rvalid = 1.

## Timing
- Reset values: init_done = 0, a_ready = b_ready = 0, a_rvalid = b_rvalid = 0, a_rdata = b_rdata = 0, a_perr = b_perr = 0, FSM = INIT, init counter = 0.
- Read latency: 1 cycle (accept at cycle N, rvalid/rdata at N+1). Back-to-back reads give one result per cycle.
- Writes are visible to any read accepted in a later cycle.
- init_done rises exactly 2**AW cycles after rst_n deasserts (counted from the first clk edge with rst_n = 1).
- rst_n asserted mid-operation:
  - Asynchronously clears all outputs and the FSM.
  - In-flight reads are dropped, with no rvalid.
  - Zero-fill restarts from address 0.
- Requests presented while ready = 0 are ignored; the requester holds them.

## Configuration
- DPRAM_PARITY_EN defined:
  - Stores one even-parity bit per byte alongside data.
  - Parity is written per enabled byte.
  - On read, parity is recomputed. perr is the OR of byte mismatches, asserted with rvalid.
  - Forwarded bytes use the writer's computed parity.
- DPRAM_PARITY_EN undefined: no parity storage; a_perr = b_perr = 0 constantly.

## Structure
- Shared package dpram_pkg holds:
  - FSM enum dpram_state_e {INIT, RUN}.
  - Function byte_parity(DW).
  - Function be_merge(old, new, be).
- Sub-module dpram_arb: pure collision/forwarding decision logic. Inputs: both requests. Outputs: b_stall, a_fwd_to_b, b_fwd_to_a.
- The top level holds the memory array, the INIT counter/FSM and the read registers.

## Test plan
- Reset, then hold idle -> init_done rises at cycle 4096. Reading addr 0x000 and 0xFFF returns 0x00000000, rvalid one cycle after acceptance.
- A writes 0xDEADBEEF to 0x010 with be = 4'b1111; B reads 0x010 in the same cycle -> B's rdata = 0xDEADBEEF next cycle.
- A (be = 4'b0011, 0x1111_2222) and B (be = 4'b1111, 0xAAAA_BBBB) both write 0x020 in the same cycle -> b_ready = 0 for one cycle, B retried. A later read of 0x020 returns 0xAAAA_BBBB.
- Write 0x12345678 to 0x030, then write be = 4'b0100 with 0x00FF0000 -> read returns 0x12FF5678.
- Assert rst_n low while reads are in flight -> no rvalid, all outputs 0. After release, init_done again after 4096 cycles, and memory reads 0.
- DPRAM_PARITY_EN: force one stored bit flip at 0x040 via hierarchical deposit, then read -> a_perr = 1 with rvalid. Clean reads -> perr = 0.
